// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared types and constants for the MII receive framer.
// Holds the FSM state enum, error codes, CRC-32 constants and a nibble CRC step.
package eth_rx_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_DROP
  } rx_state_e;

  localparam logic [1:0] ERR_CRC   = 2'd0;
  localparam logic [1:0] ERR_ODD   = 2'd1;
  localparam logic [1:0] ERR_LONG  = 2'd2;
  localparam logic [1:0] ERR_SHORT = 2'd3;

  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  localparam logic [3:0] NIB_PRE = 4'h5;
  localparam logic [3:0] NIB_SFD = 4'hD;

  // Reflected CRC-32 advanced by one nibble, bit 0 first.
  function automatic logic [31:0] crc32_nib(
    input logic [31:0] crc,
    input logic [3:0]  d
  );
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/mii_rx_crc32.sv
// mii_rx_crc32: nibble-wide reflected CRC-32 register with residue match.
// Ports: eth_rx_clk, rst (async high), clr_i, en_i, nib_i[3:0], match_o.
module mii_rx_crc32
  import eth_rx_pkg::*;
(
  input  logic       eth_rx_clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [3:0] nib_i,
  output logic       match_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i)     crc_d = CRC_INIT;
    else if (en_i) crc_d = crc32_nib(crc_q, nib_i);
  end

  always_ff @(posedge eth_rx_clk or posedge rst) begin
    if (rst) crc_q <= CRC_INIT;
    else     crc_q <= crc_d;
  end

  assign match_o = (crc_q == CRC_RESIDUE);

endmodule

// File: rtl/eth_mii_rx.sv
// eth_mii_rx: MII receive framer. Preamble/SFD detect, byte assembly, FCS strip.
// In: eth_rx_clk, rst, eth_rx_dv, eth_rx_data[3:0]. Out: rx_byte[7:0],
// rx_byte_valid, rx_sof, rx_eof, rx_frame_ok, rx_err_code[1:0], rx_byte_cnt[15:0].
// Macro ETH_RX_CRC_CHECK_EN builds the FCS checker (err code 0).
module eth_mii_rx
  import eth_rx_pkg::*;
#(
  parameter int unsigned PRE_MIN_NIBBLES = 7,
  parameter int unsigned MAX_BYTES       = 1518
) (
  input  logic        eth_rx_clk,
  input  logic        rst,
  input  logic        eth_rx_dv,
  input  logic [3:0]  eth_rx_data,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic        rx_frame_ok,
  output logic [1:0]  rx_err_code,
  output logic [15:0] rx_byte_cnt
);

  localparam logic [3:0]  PRE_MIN = PRE_MIN_NIBBLES[3:0];
  localparam logic [15:0] MAX_B   = MAX_BYTES[15:0];

  rx_state_e   state_q, state_d;
  logic        dv_prev_q;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic        phase_q, phase_d;
  logic [3:0]  lo_q, lo_d;
  logic [7:0]  dl_q [4];
  logic [7:0]  dl_d [4];
  logic [2:0]  dl_cnt_q, dl_cnt_d;
  logic [15:0] bcnt_q, bcnt_d;
  logic        sof_pend_q, sof_pend_d;
  logic        long_q, long_d;

  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        ok_q, ok_d;
  logic [1:0]  err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  logic [7:0]  new_byte;
  logic [15:0] pay_cnt;
  logic [15:0] bcnt_inc;

`ifdef ETH_RX_CRC_CHECK_EN
  logic crc_clr;
  logic crc_en;
  logic crc_match;

  mii_rx_crc32 u_crc (
    .eth_rx_clk (eth_rx_clk),
    .rst        (rst),
    .clr_i      (crc_clr),
    .en_i       (crc_en),
    .nib_i      (eth_rx_data),
    .match_o    (crc_match)
  );
`endif

  assign new_byte = {eth_rx_data, lo_q};
  assign pay_cnt  = (bcnt_q < 16'd4) ? 16'd0 : bcnt_q - 16'd4;
  assign bcnt_inc = (bcnt_q == 16'hFFFF) ? bcnt_q : bcnt_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    phase_d    = phase_q;
    lo_d       = lo_q;
    dl_d       = dl_q;
    dl_cnt_d   = dl_cnt_q;
    bcnt_d     = bcnt_q;
    sof_pend_d = sof_pend_q;
    long_d     = long_q;
    byte_d     = byte_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    ok_d       = ok_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
`ifdef ETH_RX_CRC_CHECK_EN
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        // The first nibble after a dv rising edge counts as preamble.
        if (eth_rx_dv && !dv_prev_q) begin
          long_d = 1'b0;
          if (eth_rx_data == NIB_PRE) begin
            state_d   = S_PRE;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_PRE: begin
        if (!eth_rx_dv) begin
          state_d = S_IDLE;
        end else if (eth_rx_data == NIB_PRE) begin
          if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if (eth_rx_data == NIB_SFD && pre_cnt_q >= PRE_MIN) begin
          state_d    = S_DATA;
          phase_d    = 1'b0;
          dl_cnt_d   = 3'd0;
          bcnt_d     = 16'd0;
          sof_pend_d = 1'b1;
`ifdef ETH_RX_CRC_CHECK_EN
          crc_clr    = 1'b1;
`endif
        end else begin
          state_d = S_DROP;
        end
      end
      S_DATA: begin
        if (!eth_rx_dv) begin
          state_d = S_IDLE;
          eof_d   = 1'b1;
          cnt_d   = pay_cnt;
          ok_d    = 1'b0;
          err_d   = ERR_CRC;
          if (phase_q) begin
            err_d = ERR_ODD;
          end else if (bcnt_q < 16'd5) begin
            err_d = ERR_SHORT;
`ifdef ETH_RX_CRC_CHECK_EN
          end else if (!crc_match) begin
            err_d = ERR_CRC;
`endif
          end else begin
            ok_d = 1'b1;
          end
        end else begin
`ifdef ETH_RX_CRC_CHECK_EN
          crc_en = 1'b1;
`endif
          if (!phase_q) begin
            lo_d    = eth_rx_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            bcnt_d  = bcnt_inc;
            if (bcnt_q == MAX_B) begin
              state_d = S_DROP;
              long_d  = 1'b1;
            end else begin
              dl_d[0] = new_byte;
              for (int i = 1; i < 4; i++) dl_d[i] = dl_q[i-1];
              // Line full: the oldest byte is payload, not FCS.
              if (dl_cnt_q == 3'd4) begin
                byte_d     = dl_q[3];
                valid_d    = 1'b1;
                sof_d      = sof_pend_q;
                sof_pend_d = 1'b0;
              end else begin
                dl_cnt_d = dl_cnt_q + 3'd1;
              end
            end
          end
        end
      end
      S_DROP: begin
        if (!eth_rx_dv) begin
          state_d = S_IDLE;
          if (long_q) begin
            eof_d = 1'b1;
            ok_d  = 1'b0;
            err_d = ERR_LONG;
            cnt_d = pay_cnt;
          end
        end
      end
    endcase
  end

  always_ff @(posedge eth_rx_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dv_prev_q  <= 1'b1;
      pre_cnt_q  <= 4'd0;
      phase_q    <= 1'b0;
      lo_q       <= 4'd0;
      for (int i = 0; i < 4; i++) dl_q[i] <= 8'd0;
      dl_cnt_q   <= 3'd0;
      bcnt_q     <= 16'd0;
      sof_pend_q <= 1'b0;
      long_q     <= 1'b0;
      byte_q     <= 8'd0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 2'd0;
      cnt_q      <= 16'd0;
    end else begin
      state_q    <= state_d;
      dv_prev_q  <= eth_rx_dv;
      pre_cnt_q  <= pre_cnt_d;
      phase_q    <= phase_d;
      lo_q       <= lo_d;
      dl_q       <= dl_d;
      dl_cnt_q   <= dl_cnt_d;
      bcnt_q     <= bcnt_d;
      sof_pend_q <= sof_pend_d;
      long_q     <= long_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rx_byte       = byte_q;
  assign rx_byte_valid = valid_q;
  assign rx_sof        = sof_q;
  assign rx_eof        = eof_q;
  assign rx_frame_ok   = ok_q;
  assign rx_err_code   = err_q;
  assign rx_byte_cnt   = cnt_q;

endmodule

// File: tb/tb_eth_mii_rx.sv
// tb_eth_mii_rx: directed bench for eth_mii_rx.
// Builds frames with a software FCS and checks stream, status and timing.
module tb_eth_mii_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        dv;
  logic [3:0]  data;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic        rx_sof;
  logic        rx_eof;
  logic        rx_frame_ok;
  logic [1:0]  rx_err_code;
  logic [15:0] rx_byte_cnt;

  eth_mii_rx dut (
    .eth_rx_clk    (clk),
    .rst           (rst),
    .eth_rx_dv     (dv),
    .eth_rx_data   (data),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .rx_sof        (rx_sof),
    .rx_eof        (rx_eof),
    .rx_frame_ok   (rx_frame_ok),
    .rx_err_code   (rx_err_code),
    .rx_byte_cnt   (rx_byte_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int          cyc = 0;
  logic [7:0]  q[$];
  int          sof_cnt, sof_idx, bad_sof;
  int          eof_cnt, eof_ok_cnt, eof_cyc;
  logic        eof_ok;
  logic [1:0]  eof_err;
  logic [15:0] eof_bc;

  logic [7:0]  fr[$];
  logic [3:0]  nq[$];
  int          t_last;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rx_sof) begin
      sof_cnt++;
      sof_idx = q.size();
      if (!rx_byte_valid || rx_eof) bad_sof++;
    end
    if (rx_byte_valid) q.push_back(rx_byte);
    if (rx_eof) begin
      eof_cnt++;
      eof_cyc = cyc;
      eof_ok  = rx_frame_ok;
      eof_err = rx_err_code;
      eof_bc  = rx_byte_cnt;
      if (rx_frame_ok) eof_ok_cnt++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    q.delete();
    sof_cnt    = 0;
    sof_idx    = -1;
    bad_sof    = 0;
    eof_cnt    = 0;
    eof_ok_cnt = 0;
    eof_cyc    = -1;
    eof_ok     = 1'bx;
    eof_err    = 2'bxx;
    eof_bc     = 'x;
  endtask

  function automatic logic [31:0] fcs_calc();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (fr[i])
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ fr[i][b]) c = (c >> 1) ^ 32'hEDB8_8320;
        else                 c = c >> 1;
      end
    return ~c;
  endfunction

  task automatic mk(input int n);
    logic [31:0] f;
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back(i[7:0]);
    f = fcs_calc();
    fr.push_back(f[7:0]);
    fr.push_back(f[15:8]);
    fr.push_back(f[23:16]);
    fr.push_back(f[31:24]);
  endtask

  task automatic nibs(input int npre, input int extra);
    nq.delete();
    for (int i = 0; i < npre; i++) nq.push_back(4'h5);
    nq.push_back(4'hD);
    foreach (fr[i]) begin
      nq.push_back(fr[i][3:0]);
      nq.push_back(fr[i][7:4]);
    end
    if (extra != 0) nq.push_back(4'h7);
  endtask

  task automatic nib(input logic v, input logic [3:0] d);
    @(negedge clk);
    dv   = v;
    data = d;
  endtask

  task automatic play(input int idle);
    foreach (nq[i]) nib(1'b1, nq[i]);
    t_last = cyc;
    repeat (idle) nib(1'b0, 4'h0);
  endtask

  task automatic chk_stream(input string tag, input int n);
    logic [7:0] v;
    chk({tag, "_n"}, q.size(), n);
    for (int i = 0; i < n; i++) begin
      v = (i < q.size()) ? q[i] : 8'hxx;
      chk({tag, "_b"}, v, i[7:0]);
    end
  endtask

  initial begin
    rst  = 1'b1;
    dv   = 1'b0;
    data = 4'h0;
    clr_mon();
    repeat (3) @(negedge clk);
    chk("rst_valid", rx_byte_valid, 1'b0);
    chk("rst_outs",
        {rx_byte, rx_sof, rx_eof, rx_frame_ok, rx_err_code, rx_byte_cnt},
        32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // good 60-byte frame
    clr_mon();
    mk(60); nibs(15, 0); play(4);
    chk_stream("good", 60);
    chk("good_sof_n", sof_cnt, 1);
    chk("good_sof_at", sof_idx, 0);
    chk("good_sof_bad", bad_sof, 0);
    chk("good_eof_n", eof_cnt, 1);
    chk("good_ok", eof_ok, 1'b1);
    chk("good_bc", eof_bc, 16'd60);
    chk("good_eof_lat", eof_cyc - t_last, 2);

    // FCS bit 0 flipped
    clr_mon();
    mk(60); fr[60] = fr[60] ^ 8'h01; nibs(15, 0); play(4);
    chk_stream("crc", 60);
    chk("crc_eof_n", eof_cnt, 1);
`ifdef ETH_RX_CRC_CHECK_EN
    chk("crc_ok", eof_ok, 1'b0);
`else
    chk("crc_ok", eof_ok, 1'b1);
`endif
    chk("crc_err", eof_err, 2'd0);
    chk("crc_bc", eof_bc, 16'd60);

    // odd nibble count
    clr_mon();
    mk(60); nibs(15, 1); play(4);
    chk("odd_n", q.size(), 60);
    chk("odd_ok", eof_ok, 1'b0);
    chk("odd_err", eof_err, 2'd1);
    chk("odd_bc", eof_bc, 16'd60);

    // zero payload: FCS only
    clr_mon();
    mk(0); nibs(8, 0); play(4);
    chk("zero_n", q.size(), 0);
    chk("zero_sof", sof_cnt, 0);
    chk("zero_eof_n", eof_cnt, 1);
    chk("zero_ok", eof_ok, 1'b0);
    chk("zero_err", eof_err, 2'd3);
    chk("zero_bc", eof_bc, 16'd0);

    // one payload byte: shortest good frame
    clr_mon();
    mk(1); nibs(7, 0); play(4);
    chk_stream("one", 1);
    chk("one_sof", sof_cnt, 1);
    chk("one_sof_bad", bad_sof, 0);
    chk("one_ok", eof_ok, 1'b1);
    chk("one_bc", eof_bc, 16'd1);

    // 1519 bytes including FCS
    clr_mon();
    mk(1515); nibs(15, 0); play(4);
    chk_stream("long", 1514);
    chk("long_eof_n", eof_cnt, 1);
    chk("long_ok", eof_ok, 1'b0);
    chk("long_err", eof_err, 2'd2);
    chk("long_bc", eof_bc, 16'd1515);

    // short preamble, then a normal frame
    clr_mon();
    mk(60); nibs(3, 0); play(4);
    chk("pre_n", q.size(), 0);
    chk("pre_eof_n", eof_cnt, 0);
    nibs(15, 0); play(4);
    chk_stream("pre_next", 60);
    chk("pre_next_ok", eof_ok, 1'b1);

    // back-to-back: dv rises right after one idle cycle
    clr_mon();
    mk(60); nibs(15, 0); play(1);
    mk(20); nibs(15, 0); play(4);
    chk("b2b_n", q.size(), 80);
    chk("b2b_sof", sof_cnt, 2);
    chk("b2b_eof_n", eof_cnt, 2);
    chk("b2b_ok_n", eof_ok_cnt, 2);
    chk("b2b_bc", eof_bc, 16'd20);

    // reset at byte 20 of a good frame, released while dv=1
    clr_mon();
    mk(60); nibs(15, 0);
    for (int i = 0; i < nq.size(); i++) begin
      nib(1'b1, nq[i]);
      if (i == 56) begin
        chk("ab_pre_n", q.size(), 16);
        rst = 1'b1;
        #1;
        chk("ab_outs",
            {rx_byte, rx_byte_valid, rx_sof, rx_eof,
             rx_frame_ok, rx_err_code, rx_byte_cnt},
            32'd0);
        clr_mon();
      end
      if (i == 58) rst = 1'b0;
    end
    nib(1'b0, 4'h0);
    chk("ab_n", q.size(), 0);
    chk("ab_eof_n", eof_cnt, 0);
    play(4);
    chk_stream("ab_next", 60);
    chk("ab_next_eof", eof_cnt, 1);
    chk("ab_next_ok", eof_ok, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
